// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream input and instruction memory write port of the boot loader
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    modport master (output rx_data, rx_valid, input rx_ready, imem_we, imem_addr, imem_data);
    modport slave  (input rx_data, rx_valid, output rx_ready, imem_we, imem_addr, imem_data);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for instruction memory; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
module imem_loader #(
    parameter logic [63:0] BASE_ADDR      = 64'h0,
    parameter int          DEPTH_WORDS    = 1024,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load_start,
    imem_loader_if.slave                   bus,
    output logic                           cpu_rst_n,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [1:0]                     err_code,
    output logic [$clog2(DEPTH_WORDS):0]   words_loaded
);
    localparam logic [31:0] TLIM = 32'(TIMEOUT_CYCLES - 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;
    localparam state_t FIN = CSUM;
    logic [7:0] sum;
`else
    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;
    localparam state_t FIN = DONE;
`endif
    state_t      state, nxt;
    logic [1:0]  code, bcnt;
    logic [31:0] word_count, wc, gap;
    logic [23:0] asm_q;
    logic        acc, tmo, start, last;

    assign busy         = state == HDR || state == DATA
`ifdef IMEM_LOADER_CHECKSUM_EN
                        || state == CSUM
`endif
                        ;
    assign bus.rx_ready = busy;
    assign cpu_rst_n    = state == DONE;
    assign done         = state == DONE;
    assign err          = state == ERR;
    assign acc          = bus.rx_valid && busy;
    assign start        = load_start && !busy;
    assign tmo          = TIMEOUT_CYCLES != 0 && busy && !acc && gap == TLIM;
    assign wc           = {bus.rx_data, word_count[31:8]};
    assign last         = 32'(words_loaded) + 32'd1 == word_count;

    // state register
    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : nxt;

    // next state and the error reason latched on entry to ERR
    always_comb begin
        nxt  = state;
        code = 2'd0;
        case (state)
            IDLE, DONE, ERR: nxt = load_start ? HDR : state;
            HDR: begin
                if (tmo) begin
                    nxt  = ERR;
                    code = 2'd2;
                end else if (acc && bcnt == 2'd3) begin
                    nxt  = wc > 32'(DEPTH_WORDS) ? ERR : wc == 32'd0 ? FIN : DATA;
                    code = wc > 32'(DEPTH_WORDS) ? 2'd1 : 2'd0;
                end
            end
            DATA: begin
                if (tmo) begin
                    nxt  = ERR;
                    code = 2'd2;
                end else if (acc && bcnt == 2'd3 && last)
                    nxt = FIN;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (tmo) begin
                    nxt  = ERR;
                    code = 2'd2;
                end else if (acc) begin
                    nxt  = 8'(sum + bus.rx_data) == 8'd0 ? DONE : ERR;
                    code = 8'(sum + bus.rx_data) == 8'd0 ? 2'd0 : 2'd3;
                end
            end
`endif
            default: nxt = IDLE;
        endcase
    end

    // header capture, word assembly, write issue, idle-gap counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcnt          <= '0;
            word_count    <= '0;
            asm_q         <= '0;
            gap           <= '0;
            words_loaded  <= '0;
            err_code      <= '0;
            bus.imem_we   <= 1'b0;
            bus.imem_addr <= '0;
            bus.imem_data <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum           <= '0;
`endif
        end else begin
            bus.imem_we <= 1'b0;
            if (busy)
                gap <= acc ? 32'd0 : gap + 32'd1;
            if (acc) begin
                bcnt <= bcnt + 2'd1;
                if (state == HDR)
                    word_count <= wc;
                if (state == DATA) begin
                    asm_q <= {bus.rx_data, asm_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum   <= sum + bus.rx_data;
`endif
                    if (bcnt == 2'd3) begin
                        bus.imem_we   <= 1'b1;
                        bus.imem_addr <= BASE_ADDR + (64'(words_loaded) << 2);
                        bus.imem_data <= {bus.rx_data, asm_q};
                        words_loaded  <= words_loaded + 1'b1;
                    end
                end
            end
            if (nxt == ERR && state != ERR)
                err_code <= code;
            if (start) begin
                bcnt         <= '0;
                gap          <= '0;
                words_loaded <= '0;
                err_code     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum          <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (honours IMEM_LOADER_CHECKSUM_EN)
module tb_imem_loader;
    logic        clk = 1'b0, rst_n = 1'b0, load_start = 1'b0;
    logic        cpu_rst_n, busy, done, err;
    logic [1:0]  err_code;
    logic [10:0] words_loaded;
    int          checks = 0, failures = 0;
    logic [63:0] wa[$];
    logic [31:0] wd[$];

    imem_loader_if bus();

    imem_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .bus(bus.slave),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // log every write pulse
    always @(negedge clk)
        if (bus.imem_we) begin
            wa.push_back(bus.imem_addr);
            wd.push_back(bus.imem_data);
        end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) chk("send_ready", bus.rx_ready, 1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    endtask

    task automatic pulse();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rx_ready"}, bus.rx_ready, 0);
        chk({tag, "_we"}, bus.imem_we, 0);
        chk({tag, "_addr"}, bus.imem_addr, 0);
        chk({tag, "_data"}, bus.imem_data, 0);
        chk({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_code"}, err_code, 0);
        chk({tag, "_words"}, words_loaded, 0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        pulse();
        chk("t1_busy", busy, 1);
        chk("t1_cpu_low", cpu_rst_n, 0);
        send_word(32'd2);
        send_word(32'h00500013);
        send_word(32'h00100093);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'hFA);
`endif
        @(negedge clk);
        chk("t1_nwrites", wa.size(), 2);
        chk("t1_addr0", wa[0], 64'h0);
        chk("t1_data0", wd[0], 32'h00500013);
        chk("t1_addr1", wa[1], 64'h4);
        chk("t1_data1", wd[1], 32'h00100093);
        chk("t1_done", done, 1);
        chk("t1_cpu", cpu_rst_n, 1);
        chk("t1_words", words_loaded, 2);
        chk("t1_err", err, 0);

        pulse();
        chk("t2_done_clr", done, 0);
        chk("t2_words_clr", words_loaded, 0);
        send_word(32'd1025);
        @(negedge clk);
        chk("t2_err", err, 1);
        chk("t2_code", err_code, 1);
        chk("t2_cpu", cpu_rst_n, 0);
        chk("t2_nwrites", wa.size(), 2);
        chk("t2_busy", busy, 0);

        pulse();
        chk("t3_err_clr", err, 0);
        chk("t3_code_clr", err_code, 0);
        send_word(32'd1);
        send(8'h13);
        send(8'h00);
        repeat (15) @(negedge clk);
        chk("t3_early_err", err, 0);
        chk("t3_early_busy", busy, 1);
        @(negedge clk);
        chk("t3_err", err, 1);
        chk("t3_code", err_code, 2);
        chk("t3_nwrites", wa.size(), 2);

        pulse();
        send(8'h00);
        send(8'h00);
        pulse();
        send(8'h00);
        send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        @(negedge clk);
        chk("t4_done", done, 1);
        chk("t4_cpu", cpu_rst_n, 1);
        chk("t4_words", words_loaded, 0);
        chk("t4_nwrites", wa.size(), 2);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_cpu_drop", cpu_rst_n, 0);
        chk("t4_restart_busy", busy, 1);
        @(negedge clk);
        load_start = 1'b0;

        send_word(32'd1024);
        chk("t5_depth_busy", busy, 1);
        chk("t5_depth_err", err, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_depth_rst_busy", busy, 0);

        pulse();
        send_word(32'd2);
        send_word(32'h00500013);
        send(8'h93);
        send(8'h00);
        @(negedge clk);
        chk("t6_nwrites", wa.size(), 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset("t6");
        bus.rx_data  = 8'h10;
        bus.rx_valid = 1'b1;
        repeat (6) @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("t6_no_more_we", wa.size(), 3);
        chk("t6_idle_busy", busy, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse();
        send_word(32'd2);
        send_word(32'h00500013);
        send_word(32'h00100093);
        send(8'hFB);
        @(negedge clk);
        chk("t7_err", err, 1);
        chk("t7_code", err_code, 3);
        chk("t7_nwrites", wa.size(), 5);
        chk("t7_cpu", cpu_rst_n, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
